// File: rtl/pwm_soc_pkg.sv
// Shared register map, CTRL encodings and sequencer state codes for the PWM soft-start block.
package pwm_soc_pkg;

    localparam logic [7:0] REG_CTRL      = 8'h00;
    localparam logic [7:0] REG_FREQ_DIV  = 8'h04;
    localparam logic [7:0] REG_MOD_INDEX = 8'h08;
    localparam logic [7:0] REG_SINE_FREQ = 8'h10;
    localparam logic [7:0] REG_DEADTIME  = 8'h14;

    localparam logic [31:0] CTRL_DISABLE = 32'd0;
    localparam logic [31:0] CTRL_ENABLE  = 32'd1;

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] WR_DIS    = 4'd1;
    localparam logic [3:0] WR_FDIV   = 4'd2;
    localparam logic [3:0] WR_SINE   = 4'd3;
    localparam logic [3:0] WR_DT     = 4'd4;
    localparam logic [3:0] WR_MOD    = 4'd5;
    localparam logic [3:0] WR_EN     = 4'd6;
    localparam logic [3:0] RAMP_WAIT = 4'd7;
    localparam logic [3:0] RAMP_WR   = 4'd8;
    localparam logic [3:0] RUN       = 4'd9;
    localparam logic [3:0] WR_OFF    = 4'd10;
    localparam logic [3:0] FAULT     = 4'd11;

    // 17-bit sum so the saturation compare never sees a wrapped value
    function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                              input logic [15:0] step,
                                              input logic [15:0] limit);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, step};
        return (sum > {1'b0, limit}) ? limit : sum[15:0];
    endfunction

endpackage

// File: rtl/wb_single_writer.sv
// Single Wishbone write engine: holds stb/addr/data until ack, aborts after ACK_TIMEOUT idle-ack cycles.
module wb_single_writer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic [7:0]  addr,
    input  logic [31:0] data,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  wb_addr,
    output logic [31:0] wb_dat_o,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic        wb_stb,
    input  logic        wb_ack
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    logic          stb;
    logic [7:0]    addr_q;
    logic [31:0]   data_q;
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb      <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            wait_cnt <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            if (stb) begin
                if (wb_ack) begin
                    stb      <= 1'b0;
                    done     <= 1'b1;
                    wait_cnt <= '0;
                end else if (wait_cnt == CW'(ACK_TIMEOUT - 1)) begin
                    stb      <= 1'b0;
                    timeout  <= 1'b1;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else if (go) begin
                stb      <= 1'b1;
                addr_q   <= addr;
                data_q   <= data;
                wait_cnt <= '0;
            end
        end
    end

    assign wb_stb   = stb;
    assign wb_we    = stb;
    assign wb_sel   = stb ? 4'hF : 4'h0;
    assign wb_addr  = stb ? addr_q : '0;
    assign wb_dat_o = stb ? data_q : '0;

endmodule

// File: rtl/pwm_softstart_sequencer.sv
// PWM enable/soft-start sequencer driving a Wishbone PWM slave.
// Optional MOD_INDEX ramp enabled by defining PWM_SOFTSTART_RAMP_EN.
module pwm_softstart_sequencer
    import pwm_soc_pkg::*;
#(
    parameter int FREQ_DIV      = 5000,
    parameter int SINE_FREQ     = 17,
    parameter int DEADTIME      = 50,
    parameter int MOD_TARGET    = 32767,
    parameter int RAMP_STEP     = 1024,
    parameter int RAMP_INTERVAL = 50000,
    parameter int ACK_TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        fault,
    output logic [7:0]  wb_addr,
    output logic [31:0] wb_dat_o,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic        wb_stb,
    input  logic        wb_ack,
    output logic        busy,
    output logic        running,
    output logic        ramping,
    output logic        err
);
    logic [3:0]  state;
    logic [3:0]  next_wr;
    logic        issued;
    logic        fault_pend;
    logic        stop_pend;
    logic [15:0] mod_cur;
    logic        at_target;
    logic        is_wr;
    logic        go;
    logic        done;
    logic        timeout;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

`ifdef PWM_SOFTSTART_RAMP_EN
    localparam logic [15:0] MOD_INIT = (RAMP_STEP < MOD_TARGET) ? 16'(RAMP_STEP) : 16'(MOD_TARGET);
    logic [31:0] ramp_cnt;
    logic        ramp_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ramp_cnt <= '0;
        else if (state == RAMP_WAIT && !ramp_done)
            ramp_cnt <= ramp_cnt + 32'd1;
        else
            ramp_cnt <= '0;
    end

    assign ramp_done = (state == RAMP_WAIT) && (ramp_cnt == 32'(RAMP_INTERVAL - 1));
    assign ramping   = state inside {WR_MOD, WR_EN, RAMP_WAIT, RAMP_WR};
`else
    localparam logic [15:0] MOD_INIT = 16'(MOD_TARGET);
    assign ramping = 1'b0;
`endif

    assign at_target = (mod_cur == 16'(MOD_TARGET));
    assign is_wr     = state inside {WR_DIS, WR_FDIV, WR_SINE, WR_DT, WR_MOD, WR_EN, RAMP_WR, WR_OFF};
    assign go        = is_wr && !issued;
    assign busy      = is_wr;
    assign running   = (state == RUN);

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        next_wr = IDLE;
        case (state)
            WR_DIS:  begin wr_addr = REG_CTRL;      wr_data = CTRL_DISABLE;              next_wr = WR_FDIV; end
            WR_FDIV: begin wr_addr = REG_FREQ_DIV;  wr_data = {16'b0, 16'(FREQ_DIV)};    next_wr = WR_SINE; end
            WR_SINE: begin wr_addr = REG_SINE_FREQ; wr_data = {16'b0, 16'(SINE_FREQ)};   next_wr = WR_DT;   end
            WR_DT:   begin wr_addr = REG_DEADTIME;  wr_data = {16'b0, 16'(DEADTIME)};    next_wr = WR_MOD;  end
            WR_MOD:  begin wr_addr = REG_MOD_INDEX; wr_data = {16'b0, mod_cur};          next_wr = WR_EN;   end
            WR_EN: begin
                wr_addr = REG_CTRL;
                wr_data = CTRL_ENABLE;
`ifdef PWM_SOFTSTART_RAMP_EN
                next_wr = at_target ? RUN : RAMP_WAIT;
`else
                next_wr = RUN;
`endif
            end
            RAMP_WR: begin wr_addr = REG_MOD_INDEX; wr_data = {16'b0, mod_cur}; next_wr = at_target ? RUN : RAMP_WAIT; end
            WR_OFF:  begin wr_addr = REG_CTRL;      wr_data = CTRL_DISABLE;     next_wr = IDLE; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            issued     <= 1'b0;
            fault_pend <= 1'b0;
            stop_pend  <= 1'b0;
            mod_cur    <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop && !fault) begin
                        state   <= WR_DIS;
                        mod_cur <= MOD_INIT;
                    end
                end
                FAULT: begin
                    if (start && !fault) begin
                        state <= IDLE;
                        err   <= 1'b0;
                    end
                end
                RUN: begin
                    if (fault) begin
                        fault_pend <= 1'b1;
                        state      <= WR_OFF;
                    end else if (stop) begin
                        state <= WR_OFF;
                    end
                end
`ifdef PWM_SOFTSTART_RAMP_EN
                RAMP_WAIT: begin
                    if (fault) begin
                        fault_pend <= 1'b1;
                        state      <= WR_OFF;
                    end else if (stop) begin
                        state <= WR_OFF;
                    end else if (ramp_done) begin
                        mod_cur <= sat_add16(mod_cur, 16'(RAMP_STEP), 16'(MOD_TARGET));
                        state   <= RAMP_WR;
                    end
                end
`endif
                WR_DIS, WR_FDIV, WR_SINE, WR_DT, WR_MOD, WR_EN, RAMP_WR, WR_OFF: begin
                    // stop/fault arriving mid-write are latched and acted on once the write finishes
                    if (go)    issued     <= 1'b1;
                    if (fault) fault_pend <= 1'b1;
                    if (stop)  stop_pend  <= 1'b1;
                    if (timeout) begin
                        state      <= FAULT;
                        err        <= 1'b1;
                        issued     <= 1'b0;
                        fault_pend <= 1'b0;
                        stop_pend  <= 1'b0;
                    end else if (done) begin
                        issued <= 1'b0;
                        if (state == WR_OFF) begin
                            fault_pend <= 1'b0;
                            stop_pend  <= 1'b0;
                            if (fault_pend || fault) begin
                                state <= FAULT;
                                err   <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (fault_pend || fault) begin
                            fault_pend <= 1'b1;
                            state      <= WR_OFF;
                        end else if (stop_pend || stop) begin
                            stop_pend <= 1'b0;
                            state     <= WR_OFF;
                        end else begin
                            state <= next_wr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    wb_single_writer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_writer (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .addr     (wr_addr),
        .data     (wr_data),
        .done     (done),
        .timeout  (timeout),
        .wb_addr  (wb_addr),
        .wb_dat_o (wb_dat_o),
        .wb_we    (wb_we),
        .wb_sel   (wb_sel),
        .wb_stb   (wb_stb),
        .wb_ack   (wb_ack)
    );

endmodule

// File: tb/tb_pwm_softstart_sequencer.sv
// Self-checking bench for pwm_softstart_sequencer with a random-latency Wishbone slave model.
module tb_pwm_softstart_sequencer;
    localparam int P_FREQ_DIV = 5000;
    localparam int P_SINE     = 17;
    localparam int P_DT       = 50;
    localparam int P_TARGET   = 32767;
    localparam int P_STEP     = 1024;
    localparam int P_INTERVAL = 100;
    localparam int P_TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        fault = 1'b0;
    logic [7:0]  wb_addr;
    logic [31:0] wb_dat_o;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_stb;
    logic        wb_ack = 1'b0;
    logic        busy, running, ramping, err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] c;
    } wr_t;

    wr_t         log_q[$];
    wr_t         exp_q[$];
    logic [31:0] cyc = '0;
    int unsigned run_len = 0, last_run = 0, lat = 0, lat_cnt = 0;
    logic [7:0]  first_a = '0;
    logic [31:0] first_d = '0;
    logic        mute_en = 1'b0;
    logic [7:0]  mute_addr = '0;
    logic        saw_ramping = 1'b0;

    always #5 clk = ~clk;

    pwm_softstart_sequencer #(
        .FREQ_DIV      (P_FREQ_DIV),
        .SINE_FREQ     (P_SINE),
        .DEADTIME      (P_DT),
        .MOD_TARGET    (P_TARGET),
        .RAMP_STEP     (P_STEP),
        .RAMP_INTERVAL (P_INTERVAL),
        .ACK_TIMEOUT   (P_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .fault    (fault),
        .wb_addr  (wb_addr),
        .wb_dat_o (wb_dat_o),
        .wb_we    (wb_we),
        .wb_sel   (wb_sel),
        .wb_stb   (wb_stb),
        .wb_ack   (wb_ack),
        .busy     (busy),
        .running  (running),
        .ramping  (ramping),
        .err      (err)
    );

    // Slave model and bus monitor, evaluated 2 time units after each rising edge
    always begin
        @(posedge clk);
        #2;
        cyc = cyc + 1;
        if (!rst_n) begin
            wb_ack  = 1'b0;
            run_len = 0;
        end else begin
            if (ramping) saw_ramping = 1'b1;
            if (wb_stb) begin
                if (run_len == 0) begin
                    first_a = wb_addr;
                    first_d = wb_dat_o;
                    lat     = $urandom_range(0, 3);
                    lat_cnt = 0;
                end
                run_len++;
                checks++;
                if (wb_addr !== first_a || wb_dat_o !== first_d || wb_we !== 1'b1 || wb_sel !== 4'hF) begin
                    errors++;
                    $display("FAIL bus_hold: addr %h dat %h we %b sel %h, required addr %h dat %h we 1 sel f",
                             wb_addr, wb_dat_o, wb_we, wb_sel, first_a, first_d);
                end
                if (wb_ack) begin
                    wb_ack = 1'b0;
                end else if (!(mute_en && wb_addr == mute_addr)) begin
                    if (lat_cnt >= lat) begin
                        wb_ack = 1'b1;
                        log_q.push_back('{a: wb_addr, d: wb_dat_o, c: cyc});
                    end else begin
                        lat_cnt++;
                    end
                end
            end else begin
                wb_ack = 1'b0;
                if (run_len > 0) last_run = run_len;
                run_len = 0;
                checks++;
                if (wb_addr !== 8'h0 || wb_dat_o !== 32'h0 || wb_we !== 1'b0 || wb_sel !== 4'h0) begin
                    errors++;
                    $display("FAIL idle_bus: addr %h dat %h we %b sel %h, required all zero",
                             wb_addr, wb_dat_o, wb_we, wb_sel);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Expected enable write list derived directly from the register sequence rules
    task automatic build_enable_exp();
        int unsigned m;
        exp_q.delete();
        exp_q.push_back('{a: 8'h00, d: 32'd0, c: 32'd0});
        exp_q.push_back('{a: 8'h04, d: 32'(P_FREQ_DIV), c: 32'd0});
        exp_q.push_back('{a: 8'h10, d: 32'(P_SINE), c: 32'd0});
        exp_q.push_back('{a: 8'h14, d: 32'(P_DT), c: 32'd0});
`ifdef PWM_SOFTSTART_RAMP_EN
        m = (P_STEP < P_TARGET) ? P_STEP : P_TARGET;
        exp_q.push_back('{a: 8'h08, d: 32'(m), c: 32'd0});
        exp_q.push_back('{a: 8'h00, d: 32'd1, c: 32'd0});
        while (m != P_TARGET) begin
            m = (m + P_STEP > P_TARGET) ? P_TARGET : m + P_STEP;
            exp_q.push_back('{a: 8'h08, d: 32'(m), c: 32'd0});
        end
`else
        exp_q.push_back('{a: 8'h08, d: 32'(P_TARGET), c: 32'd0});
        exp_q.push_back('{a: 8'h00, d: 32'd1, c: 32'd0});
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({wb_stb, wb_we, busy, running, ramping, err} !== 6'b0 || wb_addr !== 8'h0 || wb_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: stb %b we %b busy %b run %b ramp %b err %b, required all 0",
                     wb_stb, wb_we, busy, running, ramping, err);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({wb_stb, busy, running, err} !== 4'b0) begin
            errors++;
            $display("FAIL post_reset_idle: stb %b busy %b run %b err %b, required all 0", wb_stb, busy, running, err);
        end
    endtask

    task automatic test_enable();
        logic [31:0] prev_c;
        logic        have_prev;
        build_enable_exp();
        log_q.delete();
        saw_ramping = 1'b0;
        pulse_start();
        for (int i = 0; i < 20000 && !running; i++) tick();
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL enable_running: running %b, required 1", running);
        end
        checks++;
        if (log_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL enable_count: %0d writes, required %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < log_q.size()) begin
                checks++;
                if (log_q[i].a !== exp_q[i].a || log_q[i].d !== exp_q[i].d) begin
                    errors++;
                    $display("FAIL enable_write[%0d]: (%h,%0d), required (%h,%0d)",
                             i, log_q[i].a, log_q[i].d, exp_q[i].a, exp_q[i].d);
                end
            end
        end
        checks++;
        if ({busy, err, ramping} !== 3'b000) begin
            errors++;
            $display("FAIL enable_status: busy %b err %b ramping %b, required 0 0 0", busy, err, ramping);
        end
`ifdef PWM_SOFTSTART_RAMP_EN
        checks++;
        if (saw_ramping !== 1'b1) begin
            errors++;
            $display("FAIL ramping_seen: %b, required 1", saw_ramping);
        end
        have_prev = 1'b0;
        prev_c = '0;
        foreach (log_q[i]) begin
            if (log_q[i].a == 8'h08) begin
                if (have_prev) begin
                    checks++;
                    if (log_q[i].c - prev_c < 32'(P_INTERVAL)) begin
                        errors++;
                        $display("FAIL ramp_spacing[%0d]: %0d cycles, required >= %0d", i, log_q[i].c - prev_c, P_INTERVAL);
                    end
                end
                have_prev = 1'b1;
                prev_c = log_q[i].c;
            end
        end
`else
        have_prev = 1'b0;
        prev_c = '0;
        checks++;
        if (saw_ramping !== 1'b0) begin
            errors++;
            $display("FAIL ramping_seen: %b, required 0 (have_prev %b prev %0d)", saw_ramping, have_prev, prev_c);
        end
`endif
    endtask

    task automatic test_stop_run();
        log_q.delete();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 200 && (busy || running); i++) tick();
        repeat (5) tick();
        checks++;
        if (log_q.size() != 1) begin
            errors++;
            $display("FAIL stop_count: %0d writes, required 1", log_q.size());
        end else begin
            checks++;
            if (log_q[0].a !== 8'h00 || log_q[0].d !== 32'd0) begin
                errors++;
                $display("FAIL stop_write: (%h,%0d), required (00,0)", log_q[0].a, log_q[0].d);
            end
        end
        checks++;
        if ({busy, running, err} !== 3'b000) begin
            errors++;
            $display("FAIL stop_status: busy %b run %b err %b, required 0 0 0", busy, running, err);
        end
    endtask

    task automatic test_start_stop_idle();
        log_q.delete();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        repeat (20) tick();
        checks++;
        if (log_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_idle: %0d writes busy %b, required 0 writes busy 0", log_q.size(), busy);
        end
    endtask

    task automatic test_fault_wait();
        log_q.delete();
        pulse_start();
        for (int i = 0; i < 300 && !(log_q.size() == 6 && !busy); i++) tick();
`ifdef PWM_SOFTSTART_RAMP_EN
        checks++;
        if (ramping !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL wait_state: ramping %b running %b, required 1 0", ramping, running);
        end
`else
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL wait_state: running %b, required 1", running);
        end
`endif
        log_q.delete();
        fault = 1'b1;
        for (int i = 0; i < 200 && !err; i++) tick();
        repeat (3) tick();
        checks++;
        if (log_q.size() != 1) begin
            errors++;
            $display("FAIL fault_count: %0d writes, required 1", log_q.size());
        end else begin
            checks++;
            if (log_q[0].a !== 8'h00 || log_q[0].d !== 32'd0) begin
                errors++;
                $display("FAIL fault_write: (%h,%0d), required (00,0)", log_q[0].a, log_q[0].d);
            end
        end
        checks++;
        if ({err, busy, running, ramping} !== 4'b1000) begin
            errors++;
            $display("FAIL fault_status: err %b busy %b run %b ramp %b, required 1 0 0 0", err, busy, running, ramping);
        end
        pulse_start();
        repeat (10) tick();
        checks++;
        if (err !== 1'b1 || log_q.size() != 1) begin
            errors++;
            $display("FAIL fault_blocks_start: err %b writes %0d, required err 1 writes 1", err, log_q.size());
        end
        fault = 1'b0;
        tick();
        pulse_start();
        repeat (5) tick();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || log_q.size() != 1) begin
            errors++;
            $display("FAIL fault_recover: err %b busy %b writes %0d, required 0 0 1", err, busy, log_q.size());
        end
    endtask

    task automatic test_timeout();
        log_q.delete();
        mute_en   = 1'b1;
        mute_addr = 8'h04;
        pulse_start();
        for (int i = 0; i < 200 && !err; i++) tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err: err %b, required 1", err);
        end
        checks++;
        if (last_run != P_TIMEOUT) begin
            errors++;
            $display("FAIL timeout_stb_len: %0d cycles, required %0d", last_run, P_TIMEOUT);
        end
        checks++;
        if (log_q.size() != 1 || wb_stb !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: writes %0d stb %b busy %b, required 1 0 0", log_q.size(), wb_stb, busy);
        end
        mute_en = 1'b0;
        pulse_start();
        repeat (5) tick();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || log_q.size() != 1) begin
            errors++;
            $display("FAIL timeout_recover: err %b busy %b writes %0d, required 0 0 1", err, busy, log_q.size());
        end
    endtask

    task automatic test_fault_mid_write();
        log_q.delete();
        pulse_start();
        for (int i = 0; i < 100 && !(wb_stb && wb_addr == 8'h04); i++) tick();
        fault = 1'b1;
        tick();
        fault = 1'b0;
        for (int i = 0; i < 200 && !err; i++) tick();
        repeat (3) tick();
        checks++;
        if (log_q.size() != 3) begin
            errors++;
            $display("FAIL midfault_count: %0d writes, required 3", log_q.size());
        end else begin
            checks++;
            if (log_q[1].a !== 8'h04 || log_q[1].d !== 32'(P_FREQ_DIV) || log_q[2].a !== 8'h00 || log_q[2].d !== 32'd0) begin
                errors++;
                $display("FAIL midfault_writes: (%h,%0d)(%h,%0d), required (04,%0d)(00,0)",
                         log_q[1].a, log_q[1].d, log_q[2].a, log_q[2].d, P_FREQ_DIV);
            end
        end
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midfault_status: err %b busy %b, required 1 0", err, busy);
        end
        pulse_start();
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL midfault_recover: err %b, required 0", err);
        end
    endtask

    task automatic test_stop_mid_write();
        log_q.delete();
        pulse_start();
        for (int i = 0; i < 100 && !(wb_stb && wb_addr == 8'h10); i++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 200 && (busy || running); i++) tick();
        repeat (3) tick();
        checks++;
        if (log_q.size() != 4) begin
            errors++;
            $display("FAIL midstop_count: %0d writes, required 4", log_q.size());
        end else begin
            checks++;
            if (log_q[2].a !== 8'h10 || log_q[2].d !== 32'(P_SINE) || log_q[3].a !== 8'h00 || log_q[3].d !== 32'd0) begin
                errors++;
                $display("FAIL midstop_writes: (%h,%0d)(%h,%0d), required (10,%0d)(00,0)",
                         log_q[2].a, log_q[2].d, log_q[3].a, log_q[3].d, P_SINE);
            end
        end
        checks++;
        if ({busy, running, err} !== 3'b000) begin
            errors++;
            $display("FAIL midstop_status: busy %b run %b err %b, required 0 0 0", busy, running, err);
        end
    endtask

    task automatic test_async_reset();
        log_q.delete();
        pulse_start();
        for (int i = 0; i < 50 && !wb_stb; i++) tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wb_stb, wb_we, busy, running, ramping, err} !== 6'b0 || wb_sel !== 4'h0 ||
            wb_addr !== 8'h0 || wb_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: stb %b we %b sel %h addr %h dat %h busy %b, required all 0",
                     wb_stb, wb_we, wb_sel, wb_addr, wb_dat_o, busy);
        end
        repeat (3) tick();
        start = 1'b1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (wb_stb !== 1'b0) begin
            errors++;
            $display("FAIL first_cycle_after_reset: stb %b, required 0", wb_stb);
        end
        start = 1'b0;
        for (int i = 0; i < 50 && busy; i++) tick();
        test_stop_run();
    endtask

    task automatic test_back_to_back();
        test_enable();
        test_stop_run();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_enable();
        test_stop_run();
        test_start_stop_idle();
        test_fault_wait();
        test_timeout();
        test_fault_mid_write();
        test_stop_mid_write();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_softstart_sequencer.md
PWM_SOFTSTART_SEQUENCER -- requirements
Module: pwm_softstart_sequencer

Interface
REQ-001 SHALL have parameters: FREQ_DIV=5000 (carrier divider); SINE_FREQ=17 (modulation step); DEADTIME=50 (dead-time cycles); MOD_TARGET=32767 (final MOD_INDEX); RAMP_STEP=1024 (MOD_INDEX increment); RAMP_INTERVAL=50000 (cycles between ramp writes); ACK_TIMEOUT=16 (max cycles waiting for wb_ack).
REQ-002 SHALL have ports: clk  in  1  system clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start  in  1  request enable sequence; stop  in  1  request orderly disable; fault  in  1  external fault, level-sensitive.
REQ-004 SHALL have Wishbone master ports: wb_addr  out  8  register address; wb_dat_o  out  32  write data; wb_we  out  1  write enable; wb_sel  out  4  byte lanes; wb_stb  out  1  strobe; wb_ack  in  1  slave acknowledge.
REQ-005 SHALL have status ports: busy  out  1  bus sequence in progress; running  out  1  PWM enabled, MOD_INDEX at MOD_TARGET; ramping  out  1  soft-start active; err  out  1  timeout or fault latched.

Function
REQ-006 SHALL use slave register map: CTRL 0x00, FREQ_DIV 0x04, MOD_INDEX 0x08, SINE_FREQ 0x10, DEADTIME 0x14; CTRL=1 means enable with auto sine, CTRL=0 means disable.
REQ-007 SHALL implement states IDLE, WR_DIS, WR_FDIV, WR_SINE, WR_DT, WR_MOD, WR_EN, RAMP_WAIT, RAMP_WR, RUN, WR_OFF, FAULT.
REQ-008 SHALL, in IDLE on start=1, write in order: CTRL=0, FREQ_DIV, SINE_FREQ, DEADTIME, MOD_INDEX=initial value, CTRL=1.
REQ-009 SHALL issue every write with wb_we=1 and wb_sel=4'b1111, hold wb_stb, wb_addr, wb_dat_o stable until wb_ack, drop wb_stb the cycle after wb_ack, and keep wb_stb low for at least one cycle before the next write.
REQ-010 SHALL count cycles with wb_stb=1 and no wb_ack; on reaching ACK_TIMEOUT it SHALL drop wb_stb, set err, and enter FAULT.
REQ-011 SHALL drive wb_dat_o bits above the field width as zero, and drive wb_addr and wb_dat_o as zero when wb_stb=0.
REQ-012 SHALL hold a 16-bit mod_cur; a ramp update SHALL set mod_cur = min(mod_cur+RAMP_STEP, MOD_TARGET), computed 17 bits wide with no wrap.
REQ-013 SHALL, in RAMP_WAIT, count RAMP_INTERVAL cycles, then write MOD_INDEX=mod_cur in RAMP_WR; it SHALL enter RUN when the written value equals MOD_TARGET.
REQ-014 SHALL, on stop=1 in RAMP_WAIT or RUN, write CTRL=0 (WR_OFF), then return to IDLE; a stop during any other write SHALL take effect once that write completes.
REQ-015 SHALL, on fault=1 in any state except IDLE and FAULT, finish or time out the current bus write, write CTRL=0, set err, and enter FAULT.
REQ-016 SHALL leave FAULT for IDLE, clearing err, only on start=1 while fault=0; fault=1 in IDLE SHALL block start.
REQ-017 SHALL ignore start outside IDLE; when start and stop are both 1 in IDLE, stop SHALL win and the block stays IDLE.
REQ-018 SHALL drive busy=1 in every write state; running=1 only in RUN; ramping=1 from WR_MOD through the final RAMP_WR.

Reset
REQ-019 SHALL, with rst_n=0, go to IDLE and clear all outputs, mod_cur, and counters to 0, regardless of any in-flight bus cycle.
REQ-020 SHALL issue no bus cycle in the first cycle after rst_n deasserts.

Configuration
REQ-021 SHALL, with macro PWM_SOFTSTART_RAMP_EN defined, use an initial MOD_INDEX of min(RAMP_STEP, MOD_TARGET) and run the ramp per REQ-012/013.
REQ-022 SHALL, without PWM_SOFTSTART_RAMP_EN, write MOD_INDEX=MOD_TARGET directly, go from WR_EN to RUN, hold ramping=0, and omit the ramp timer logic.

Structure
REQ-023 SHALL keep register offsets, CTRL encodings, and the state enumeration in shared package pwm_soc_pkg.
REQ-024 SHALL place the Wishbone single-write engine (stb/ack/timeout) in sub-module wb_single_writer, with the FSM issuing addr/data/go and receiving done/timeout.

Verification
REQ-025 Ramp off, slave acks after 1 cycle, start pulse -> writes (0x00,0),(0x04,5000),(0x10,17),(0x14,50),(0x08,32767),(0x00,1) in order, then running=1.
REQ-026 Ramp on, RAMP_INTERVAL=100 -> MOD_INDEX writes 1024,2048,...,31744,32767 (32 writes), spaced ≥100 cycles apart, then running=1.
REQ-027 Slave never acks at the FREQ_DIV write -> wb_stb drops after 16 cycles, err=1, FAULT; a later start with fault=0 returns to IDLE.
REQ-028 fault=1 during RAMP_WAIT -> one write (0x00,0), err=1, FAULT; start while fault=1 ignored.
REQ-029 stop in RUN -> single write (0x00,0), then IDLE with busy=0 and running=0.
REQ-030 rst_n=0 mid-write with wb_stb=1 -> wb_stb=0 and all outputs 0 immediately (asynchronous).
